// File: rtl/imem_fetch_ctrl.sv
// Single-port instruction memory sequencer: boot-time loader writes, then arbitrated
// IF fetch / debug reads with a starvation guard, stopping on the halt sentinel.
module imem_fetch_ctrl #(
  parameter int unsigned AW     = 10,
  parameter int unsigned STARVE = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_ld_valid,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [31:0]   i_ld_data,
  output logic          o_ld_ready,
  input  logic          i_ld_done,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_valid,
  output logic [31:0]   o_if_instr,
  input  logic          i_dbg_req,
  input  logic [AW-1:0] i_dbg_addr,
  output logic          o_dbg_gnt,
  output logic          o_dbg_valid,
  output logic [31:0]   o_dbg_data,
  output logic          o_mem_we,
  output logic          o_mem_re,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_rdata,
  input  logic          i_restart,
  output logic          o_halted,
  output logic [15:0]   o_fetch_count
);

  localparam logic [31:0] HaltWord  = 32'hFFFF_FFFF;
  localparam logic [3:0]  StarveLim = 4'(STARVE);

  typedef enum logic [1:0] {StLoad, StRun, StHalt} state_e;
  typedef enum logic [1:0] {OwnNone, OwnIf, OwnDbg} owner_e;

  state_e      r_state;
  owner_e      r_owner;
  logic [3:0]  r_starve;
  logic [31:0] r_if_instr;
  logic [31:0] r_dbg_data;
  logic        r_halted;
  logic [15:0] r_fetch_count;

  logic w_if_valid;
  logic w_dbg_valid;
  logic w_halt_trig;
  logic w_dbg_force;
  logic w_if_gnt;
  logic w_dbg_gnt;

  // Valids are qualified by reset so a read in flight when reset asserts is never delivered.
  assign w_if_valid  = i_rst_n && (r_owner == OwnIf);
  assign w_dbg_valid = i_rst_n && (r_owner == OwnDbg);
  assign w_halt_trig = w_if_valid && (i_mem_rdata == HaltWord);
  assign w_dbg_force = (r_starve >= StarveLim);

  assign o_if_gnt      = w_if_gnt;
  assign o_dbg_gnt     = w_dbg_gnt;
  assign o_if_valid    = w_if_valid;
  assign o_dbg_valid   = w_dbg_valid;
  assign o_if_instr    = w_if_valid ? i_mem_rdata : r_if_instr;
  assign o_dbg_data    = w_dbg_valid ? i_mem_rdata : r_dbg_data;
  assign o_halted      = r_halted;
  assign o_fetch_count = r_fetch_count;

  always_comb begin
    w_if_gnt    = 1'b0;
    w_dbg_gnt   = 1'b0;
    o_ld_ready  = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_re    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (i_rst_n) begin
      unique case (r_state)
        StLoad: begin
          o_ld_ready = 1'b1;
          if (i_ld_valid) begin
            o_mem_we    = 1'b1;
            o_mem_addr  = i_ld_addr;
            o_mem_wdata = i_ld_data;
          end
        end
        StRun: begin
          // The sentinel cycle issues no new read.
          if (!w_halt_trig) begin
            if (i_dbg_req && (w_dbg_force || !i_if_req)) begin
              w_dbg_gnt = 1'b1;
            end else if (i_if_req) begin
              w_if_gnt = 1'b1;
            end
          end
        end
        StHalt: w_dbg_gnt = i_dbg_req;
        default: ;
      endcase
      if (w_if_gnt) begin
        o_mem_re   = 1'b1;
        o_mem_addr = i_if_addr;
      end else if (w_dbg_gnt) begin
        o_mem_re   = 1'b1;
        o_mem_addr = i_dbg_addr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= StLoad;
      r_owner       <= OwnNone;
      r_starve      <= '0;
      r_if_instr    <= '0;
      r_dbg_data    <= '0;
      r_halted      <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      unique case (r_state)
        StLoad: if (i_ld_done) r_state <= StRun;
        StRun: begin
          if (w_halt_trig) begin
            r_state  <= StHalt;
            r_halted <= 1'b1;
          end
        end
        StHalt: begin
          if (i_restart) begin
            r_state  <= StLoad;
            r_halted <= 1'b0;
          end
        end
        default: r_state <= StLoad;
      endcase

      r_owner <= w_if_gnt ? OwnIf : (w_dbg_gnt ? OwnDbg : OwnNone);

      if (w_dbg_gnt || !i_dbg_req) begin
        r_starve <= '0;
      end else if (r_starve != 4'hF) begin
        r_starve <= r_starve + 4'd1;
      end

      if (w_if_valid) begin
        r_if_instr <= i_mem_rdata;
        if (r_fetch_count != 16'hFFFF) r_fetch_count <= r_fetch_count + 16'd1;
      end
      if (w_dbg_valid) r_dbg_data <= i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: behavioural memory, vector table, corner sequences and a
// randomized run checked against an arbitration/delivery model.
module tb_imem_fetch_ctrl;
  localparam int unsigned AW     = 10;
  localparam int unsigned STARVE = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_valid, ld_done, ld_ready;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          if_req, if_gnt, if_valid;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_instr;
  logic          dbg_req, dbg_gnt, dbg_valid;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_data;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          restart, halted;
  logic [15:0]   fetch_count;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.AW(AW), .STARVE(STARVE)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ld_valid(ld_valid), .i_ld_addr(ld_addr), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
    .i_ld_done(ld_done),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt), .o_if_valid(if_valid),
    .o_if_instr(if_instr),
    .i_dbg_req(dbg_req), .i_dbg_addr(dbg_addr), .o_dbg_gnt(dbg_gnt), .o_dbg_valid(dbg_valid),
    .o_dbg_data(dbg_data),
    .o_mem_we(mem_we), .o_mem_re(mem_re), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
    .i_restart(restart), .o_halted(halted), .o_fetch_count(fetch_count)
  );

  // Synchronous-read memory attached to the DUT port.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic          ifr;
    logic [AW-1:0] ia;
    logic          dr;
    logic [AW-1:0] da;
    logic          eig;
    logic          edg;
    logic [AW-1:0] eaddr;
    logic [31:0]   edata;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } ld_t;

  int          checks = 0;
  int          errors = 0;
  int          exp_fetch = 0;
  logic [31:0] last_if = '0;
  logic [31:0] last_dbg = '0;
  logic [31:0] ref_mem [1024];
  vec_t        vecs [8];
  ld_t         loads [9];
  logic [AW-1:0] safe [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld_valid = 1'b0; ld_done = 1'b0; ld_addr = '0; ld_data = '0;
    if_req = 1'b0; if_addr = '0; dbg_req = 1'b0; dbg_addr = '0; restart = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
    chk({tag, "_if_gnt"}, 32'(if_gnt), 32'd0);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_if_instr"}, if_instr, 32'd0);
    chk({tag, "_dbg_gnt"}, 32'(dbg_gnt), 32'd0);
    chk({tag, "_dbg_valid"}, 32'(dbg_valid), 32'd0);
    chk({tag, "_dbg_data"}, dbg_data, 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_re"}, 32'(mem_re), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_fetch_count"}, 32'(fetch_count), 32'd0);
  endtask

  initial begin
    logic          ifr, dr, iwin, dwin, p_if, p_dbg, if_hold, dbg_hold;
    logic [AW-1:0] ia, da;
    logic [31:0]   p_data;
    int            dwait;

    loads[0] = '{10'd0, 32'h0001_1020};
    loads[1] = '{10'd1, 32'h0061_1020};
    loads[2] = '{10'd2, 32'h0022_1820};
    loads[3] = '{10'd3, 32'hFFFF_FFFF};
    loads[4] = '{10'd10, 32'hA000_000A};
    loads[5] = '{10'd11, 32'hA000_000B};
    loads[6] = '{10'd12, 32'hA000_000C};
    loads[7] = '{10'd13, 32'hA000_000D};
    loads[8] = '{10'd7, 32'h0000_1234};

    vecs[0] = '{1'b1, 10'd0, 1'b0, 10'd0, 1'b1, 1'b0, 10'd0, 32'h0001_1020};
    vecs[1] = '{1'b0, 10'd0, 1'b1, 10'd1, 1'b0, 1'b1, 10'd1, 32'h0061_1020};
    vecs[2] = '{1'b1, 10'd10, 1'b1, 10'd11, 1'b1, 1'b0, 10'd10, 32'hA000_000A};
    vecs[3] = '{1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0000_0000};
    vecs[4] = '{1'b1, 10'd13, 1'b0, 10'd0, 1'b1, 1'b0, 10'd13, 32'hA000_000D};
    vecs[5] = '{1'b0, 10'd0, 1'b1, 10'd12, 1'b0, 1'b1, 10'd12, 32'hA000_000C};
    vecs[6] = '{1'b0, 10'd0, 1'b1, 10'd3, 1'b0, 1'b1, 10'd3, 32'hFFFF_FFFF};
    vecs[7] = '{1'b1, 10'd2, 1'b1, 10'd2, 1'b1, 1'b0, 10'd2, 32'h0022_1820};

    safe = '{10'd0, 10'd1, 10'd2, 10'd7, 10'd10, 10'd11, 10'd12, 10'd13};

    // Reset
    rst_n = 1'b0;
    idle();
    cyc();
    cyc();
    chk_all_zero("reset");
    cyc();

    // Boot load; the last beat carries ld_done. Requests during LOAD must not be granted.
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ld_valid = 1'b1;
      ld_addr  = loads[i].a;
      ld_data  = loads[i].d;
      ld_done  = (i == 8);
      if_req   = 1'b1; if_addr = 10'd5;
      dbg_req  = 1'b1; dbg_addr = 10'd6;
      ref_mem[loads[i].a] = loads[i].d;
      #1;
      chk("load_ready", 32'(ld_ready), 32'd1);
      chk("load_we", 32'(mem_we), 32'd1);
      chk("load_addr", 32'(mem_addr), 32'(loads[i].a));
      chk("load_wdata", mem_wdata, loads[i].d);
      chk("load_no_if_gnt", 32'(if_gnt), 32'd0);
      chk("load_no_dbg_gnt", 32'(dbg_gnt), 32'd0);
      cyc();
    end

    // First cycle of RUN: fetch of the word written with ld_done.
    idle();
    if_req = 1'b1; if_addr = 10'd7;
    #1;
    chk("run_ld_ready", 32'(ld_ready), 32'd0);
    chk("done_fetch_gnt", 32'(if_gnt), 32'd1);
    chk("done_fetch_addr", 32'(mem_addr), 32'd7);
    exp_fetch++;
    cyc();
    idle();
    #1;
    chk("done_fetch_valid", 32'(if_valid), 32'd1);
    chk("done_fetch_data", if_instr, 32'h0000_1234);
    last_if = 32'h0000_1234;
    cyc();

    // Vector table: one request cycle, then one idle cycle to observe the delivery.
    for (int i = 0; i < 8; i++) begin
      if_req = vecs[i].ifr; if_addr = vecs[i].ia;
      dbg_req = vecs[i].dr; dbg_addr = vecs[i].da;
      #1;
      chk("vec_if_gnt", 32'(if_gnt), 32'(vecs[i].eig));
      chk("vec_dbg_gnt", 32'(dbg_gnt), 32'(vecs[i].edg));
      chk("vec_mem_re", 32'(mem_re), 32'(vecs[i].eig | vecs[i].edg));
      chk("vec_mem_addr", 32'(mem_addr), 32'(vecs[i].eaddr));
      if (vecs[i].eig) exp_fetch++;
      cyc();
      idle();
      #1;
      chk("vec_if_valid", 32'(if_valid), 32'(vecs[i].eig));
      chk("vec_dbg_valid", 32'(dbg_valid), 32'(vecs[i].edg));
      if (vecs[i].eig) last_if = vecs[i].edata;
      if (vecs[i].edg) last_dbg = vecs[i].edata;
      chk("vec_if_instr", if_instr, last_if);
      chk("vec_dbg_data", dbg_data, last_dbg);
      chk("vec_halted", 32'(halted), 32'd0);
      cyc();
    end

    // Starvation: debug loses four cycles, wins the fifth, then fetch resumes.
    if_req = 1'b1; if_addr = 10'd10;
    dbg_req = 1'b1; dbg_addr = 10'd11;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("starve_if_gnt", 32'(if_gnt), 32'd1);
      chk("starve_dbg_wait", 32'(dbg_gnt), 32'd0);
      exp_fetch++;
      cyc();
    end
    #1;
    chk("starve_dbg_gnt", 32'(dbg_gnt), 32'd1);
    chk("starve_if_blocked", 32'(if_gnt), 32'd0);
    chk("starve_dbg_addr", 32'(mem_addr), 32'd11);
    cyc();
    dbg_req = 1'b0;
    #1;
    chk("starve_dbg_valid", 32'(dbg_valid), 32'd1);
    chk("starve_dbg_data", dbg_data, 32'hA000_000B);
    chk("starve_if_quiet", 32'(if_valid), 32'd0);
    chk("starve_if_held", if_instr, 32'hA000_000A);
    chk("starve_resume", 32'(if_gnt), 32'd1);
    last_dbg = 32'hA000_000B;
    last_if  = 32'hA000_000A;
    exp_fetch++;
    cyc();
    idle();
    #1;
    chk("starve_last_valid", 32'(if_valid), 32'd1);
    cyc();
    #1;
    chk("starve_fetch_count", 32'(fetch_count), 32'(exp_fetch));
    cyc();

    // restart and ld_done in RUN are ignored.
    restart = 1'b1; ld_done = 1'b1;
    cyc();
    idle();
    #1;
    chk("ignore_ld_ready", 32'(ld_ready), 32'd0);
    chk("ignore_halted", 32'(halted), 32'd0);
    cyc();

    // Randomized traffic against the arbitration/delivery model.
    dwait = 0; p_if = 1'b0; p_dbg = 1'b0; p_data = '0;
    if_hold = 1'b0; dbg_hold = 1'b0; ia = '0; da = '0;
    for (int n = 0; n < 300; n++) begin
      ifr = if_hold ? 1'b1 : 1'($urandom_range(0, 1));
      dr  = dbg_hold ? 1'b1 : 1'($urandom_range(0, 1));
      if (!if_hold) ia = safe[$urandom_range(0, 7)];
      if (!dbg_hold) da = safe[$urandom_range(0, 7)];
      if_req = ifr; if_addr = ia; dbg_req = dr; dbg_addr = da;
      #1;
      chk("rnd_if_valid", 32'(if_valid), 32'(p_if));
      chk("rnd_dbg_valid", 32'(dbg_valid), 32'(p_dbg));
      if (p_if) last_if = p_data;
      if (p_dbg) last_dbg = p_data;
      chk("rnd_if_instr", if_instr, last_if);
      chk("rnd_dbg_data", dbg_data, last_dbg);
      dwin = dr && ((dwait >= int'(STARVE)) || !ifr);
      iwin = ifr && !dwin;
      chk("rnd_if_gnt", 32'(if_gnt), 32'(iwin));
      chk("rnd_dbg_gnt", 32'(dbg_gnt), 32'(dwin));
      if (iwin || dwin) chk("rnd_mem_addr", 32'(mem_addr), 32'(iwin ? ia : da));
      dwait = (dr && !dwin) ? dwait + 1 : 0;
      p_if = iwin; p_dbg = dwin;
      p_data = ref_mem[iwin ? ia : da];
      if (iwin) exp_fetch++;
      if_hold = ifr && !iwin;
      dbg_hold = dr && !dwin;
      cyc();
    end
    idle();
    #1;
    chk("rnd_drain_if_valid", 32'(if_valid), 32'(p_if));
    chk("rnd_drain_dbg_valid", 32'(dbg_valid), 32'(p_dbg));
    if (p_if) chk("rnd_drain_if_instr", if_instr, p_data);
    if (p_dbg) chk("rnd_drain_dbg_data", dbg_data, p_data);
    if (p_if) last_if = p_data;
    if (p_dbg) last_dbg = p_data;
    cyc();
    #1;
    chk("rnd_fetch_count", 32'(fetch_count), 32'(exp_fetch));
    cyc();

    // Boot-and-fetch: addresses 0..3 back-to-back, sentinel halts, address 4 not granted.
    for (int k = 0; k <= 4; k++) begin
      if_req = 1'b1; if_addr = 10'(k);
      #1;
      if (k < 4) begin
        chk("bf_if_gnt", 32'(if_gnt), 32'd1);
        chk("bf_mem_addr", 32'(mem_addr), 32'(k));
        exp_fetch++;
      end else begin
        chk("bf_sentinel_no_gnt", 32'(if_gnt), 32'd0);
        chk("bf_sentinel_no_re", 32'(mem_re), 32'd0);
      end
      if (k > 0) begin
        chk("bf_if_valid", 32'(if_valid), 32'd1);
        chk("bf_if_instr", if_instr, loads[k-1].d);
      end
      chk("bf_not_halted", 32'(halted), 32'd0);
      cyc();
    end
    #1;
    chk("bf_halted", 32'(halted), 32'd1);
    chk("bf_halt_no_gnt", 32'(if_gnt), 32'd0);
    chk("bf_halt_no_valid", 32'(if_valid), 32'd0);
    chk("bf_halt_ld_ready", 32'(ld_ready), 32'd0);
    chk("bf_fetch_count", 32'(fetch_count), 32'(exp_fetch));
    chk("bf_sentinel_held", if_instr, 32'hFFFF_FFFF);
    cyc();

    // HALT: debug granted every cycle, then restart returns to LOAD.
    for (int j = 0; j < 3; j++) begin
      dbg_req = 1'b1; dbg_addr = 10'd2;
      #1;
      chk("halt_dbg_gnt", 32'(dbg_gnt), 32'd1);
      chk("halt_dbg_addr", 32'(mem_addr), 32'd2);
      chk("halt_if_gnt", 32'(if_gnt), 32'd0);
      if (j > 0) begin
        chk("halt_dbg_valid", 32'(dbg_valid), 32'd1);
        chk("halt_dbg_data", dbg_data, 32'h0022_1820);
      end
      cyc();
    end
    idle();
    restart = 1'b1;
    #1;
    chk("halt_last_dbg_valid", 32'(dbg_valid), 32'd1);
    chk("halt_restart_ld_ready", 32'(ld_ready), 32'd0);
    chk("halt_restart_halted", 32'(halted), 32'd1);
    cyc();
    restart = 1'b0;
    #1;
    chk("restart_ld_ready", 32'(ld_ready), 32'd1);
    chk("restart_halted", 32'(halted), 32'd0);
    chk("restart_fetch_count", 32'(fetch_count), 32'(exp_fetch));
    chk("restart_dbg_data_held", dbg_data, 32'h0022_1820);
    cyc();

    // Reset mid-read: grant in N, reset in N+1; nothing is delivered.
    ld_done = 1'b1;
    cyc();
    ld_done = 1'b0;
    if_req = 1'b1; if_addr = 10'd0;
    #1;
    chk("mid_first_gnt", 32'(if_gnt), 32'd1);
    cyc();
    rst_n = 1'b0;
    if_addr = 10'd5;
    #1;
    chk("mid_no_valid", 32'(if_valid), 32'd0);
    chk("mid_no_gnt", 32'(if_gnt), 32'd0);
    chk("mid_no_re", 32'(mem_re), 32'd0);
    cyc();
    chk_all_zero("mid_reset");
    cyc();
    rst_n = 1'b1;
    idle();
    #1;
    chk("post_rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("post_rst_if_valid", 32'(if_valid), 32'd0);
    chk("post_rst_count", 32'(fetch_count), 32'd0);

    // Fetch counter saturation: 65534 fetches, then 3 more.
    ld_done = 1'b1;
    cyc();
    ld_done = 1'b0;
    if_req = 1'b1; if_addr = 10'd1;
    repeat (65534) cyc();
    if_req = 1'b0;
    cyc();
    #1;
    chk("sat_fffe", 32'(fetch_count), 32'h0000_FFFE);
    if_req = 1'b1;
    repeat (3) cyc();
    if_req = 1'b0;
    cyc();
    #1;
    chk("sat_ffff", 32'(fetch_count), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Sequencer and arbiter for the instruction memory. It owns the memory's single port. After reset it is in a boot phase where a program loader writes instruction words. It then serves instruction fetches from the IF stage, with a starvation-guarded debug read port. It stops issuing fetches when the halt sentinel 32'hFFFFFFFF is returned.

## Interface
Parameters:
- AW, 10, word-address width (1024-word memory)
- STARVE, 4, consecutive cycles a debug request may lose arbitration before it is forced through (1..15)

Ports:
- clk  in  1  single clock; everything is on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- ld_valid / ld_addr / ld_data  in  1 / AW / 32  loader write beat
- ld_ready  out  1  loader beat accepted this cycle
- ld_done  in  1  loader finished; one-cycle pulse
- if_req / if_addr  in  1 / AW  fetch request with word address
- if_gnt  out  1  fetch request accepted this cycle
- if_valid / if_instr  out  1 / 32  fetch data, one cycle after if_gnt
- dbg_req / dbg_addr  in  1 / AW  debug read request
- dbg_gnt / dbg_valid / dbg_data  out  1 / 1 / 32  debug grant, then data one cycle later
- mem_we / mem_re / mem_addr / mem_wdata  out  1 / 1 / AW / 32  memory port; memory has synchronous read with 1-cycle latency
- mem_rdata  in  32  memory read data
- restart  in  1  pulse; in HALT, returns to LOAD
- halted  out  1  high in HALT
- fetch_count  out  16  number of fetches delivered; saturates at 16'hFFFF

## Operation
- States: LOAD, RUN, HALT. Reset enters LOAD.
- **LOAD**
  - ld_ready = 1.
  - ld_valid drives mem_we=1, mem_addr=ld_addr and mem_wdata=ld_data in the same cycle.
  - if_gnt = dbg_gnt = 0.
  - ld_done moves to RUN next cycle. A beat presented with ld_done in the same cycle is still written.
- **RUN**
  - ld_ready = 0.
  - At most one read grant per cycle. Grant drives mem_re=1 and mem_addr to the winner's address.
  - Priority is fetch over debug.
  - A 4-bit starve counter counts cycles where dbg_req=1 and dbg_gnt=0. It clears on dbg_gnt or when dbg_req=0.
  - When the counter is ≥ STARVE, debug wins that cycle.
- **Owner routing**
  - A 2-bit owner register records who was granted: none, IF or DBG.
  - The next cycle, mem_rdata goes to if_instr with if_valid, or to dbg_data with dbg_valid, per owner.
  - The data output of the non-owner holds its last value.
- **Halt detection**
  - Trigger: if_valid=1 and mem_rdata==32'hFFFFFFFF.
  - In that cycle no new grant is issued; the sentinel itself is still delivered with if_valid=1.
  - The state goes to HALT next cycle.
- **HALT**
  - if_gnt = 0 and ld_ready = 0; halted = 1.
  - dbg_req is granted every cycle it is asserted.
  - restart moves to LOAD next cycle.
- fetch_count increments on each if_valid, including the sentinel. It clears on reset only.
- restart outside HALT and ld_done outside LOAD are ignored.

## Timing
- Reset values: every output is 0, including if_instr, dbg_data and fetch_count; state = LOAD, owner = none, starve counter = 0.
- ld_ready, if_gnt, dbg_gnt and the mem_* outputs are combinational from state and requests.
- if_valid, dbg_valid, if_instr, dbg_data, halted and fetch_count are registered.
- Read latency: grant in cycle N, valid in cycle N+1. Back-to-back grants give one read per cycle.
- Reset mid-operation: any in-flight read is dropped; no valid pulse follows the reset.
- LOAD→RUN: the first fetch grant can happen in the cycle after ld_done.
- Requests held while ungranted must keep their address stable. The block never latches a request.

## Test plan
- **Boot and fetch:** load words 0..3 = {32'h00011020, 32'h00611020, 32'h00221820, 32'hFFFFFFFF}, pulse ld_done, fetch addresses 0,1,2,3 back-to-back.
  - if_valid on 4 consecutive cycles with those words.
  - halted=1 the cycle after the sentinel; fetch_count=4.
  - if_gnt=0 while if_req is held at address 4.
- **Debug starvation:** continuous if_req with dbg_req held, STARVE=4.
  - dbg_gnt on the 5th cycle (counter reaches 4), then fetch resumes.
  - dbg_data equals mem[dbg_addr] one cycle later; if_instr is unchanged that cycle.
- **Load and done together:** ld_valid with ld_done in the same cycle at address 7, data 32'h1234.
  - The word is written; state is RUN next cycle; a fetch of address 7 returns 32'h1234.
- **HALT debug and restart:**
  - In HALT, dbg_req to address 2 is granted every cycle.
  - restart gives ld_ready=1 next cycle; fetch_count is retained.
- **Reset mid-read:** if_gnt in cycle N, rst_n=0 in cycle N+1.
  - No if_valid in N+1 or later; all outputs 0; state LOAD.
- **Fetch counter saturation:** force 65537 fetches of non-sentinel words.
  - fetch_count stays at 16'hFFFF.
